// File: rtl/lane_serializer_pkg.sv
// Shared types and sizing helpers for lane_serializer.
package lane_serializer_pkg;

  localparam int SIZE = 8;

  function automatic int lane_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {IDLE, SEND, PAR} state_t;

endpackage

// File: rtl/lane_serializer.sv
// Snapshots per-lane x/y vectors and streams them one lane per beat.
// Optional trailing parity beat: define LANE_SERIALIZER_PARITY_EN.
module lane_serializer
  import lane_serializer_pkg::*;
#(
  parameter  int SIZE   = lane_serializer_pkg::SIZE,
  localparam int LANE_W = lane_w(SIZE)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [SIZE-1:0]   i_x,
  input  logic [SIZE-1:0]   i_y,
  input  logic              i_start,
  input  logic              i_ready,
  input  logic              i_drop_clr,
  output logic              o_valid,
  output logic [LANE_W-1:0] o_lane,
  output logic              o_x,
  output logic              o_y,
  output logic              o_last,
  output logic              o_par,
  output logic              o_busy,
  output logic              o_drop
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(SIZE - 1);

  state_t            state_q, state_d;
  logic [LANE_W-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0]   snap_x_q, snap_x_d;
  logic [SIZE-1:0]   snap_y_q, snap_y_d;
  logic              drop_q, drop_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      snap_x_q <= '0;
      snap_y_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      snap_x_q <= snap_x_d;
      snap_y_q <= snap_y_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    snap_x_d = snap_x_q;
    snap_y_d = snap_y_q;
    drop_d   = drop_q & ~i_drop_clr;
    o_valid  = 1'b0;
    o_busy   = 1'b0;
    o_lane   = '0;
    o_x      = 1'b0;
    o_y      = 1'b0;
    o_last   = 1'b0;
    o_par    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          snap_x_d = i_x;
          snap_y_d = i_y;
          cnt_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
        o_lane  = cnt_q;
        o_x     = snap_x_q[cnt_q];
        o_y     = snap_y_q[cnt_q];
`ifdef LANE_SERIALIZER_PARITY_EN
        o_last  = 1'b0;
`else
        o_last  = (cnt_q == LAST_LANE);
`endif
        if (i_ready) begin
          if (cnt_q == LAST_LANE) begin
`ifdef LANE_SERIALIZER_PARITY_EN
            state_d = PAR;
`else
            state_d = IDLE;
`endif
          end else begin
            cnt_d = cnt_q + LANE_W'(1);
          end
        end
      end
`ifdef LANE_SERIALIZER_PARITY_EN
      PAR: begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
        o_x     = ^snap_x_q;
        o_y     = ^snap_y_q;
        o_par   = 1'b1;
        o_last  = 1'b1;
        if (i_ready) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Any start outside IDLE is dropped; set beats a same-cycle clear.
    if (state_q != IDLE && i_start) drop_d = 1'b1;
  end

  assign o_drop = drop_q;

endmodule

// File: tb/tb_lane_serializer.sv
// Scoreboard bench for lane_serializer: stimulus pushes expected beats, monitor pops.
module tb_lane_serializer;
  localparam int SIZE = 8;
  localparam int LW   = 3;

  typedef struct packed {
    logic [LW-1:0] lane;
    logic          x;
    logic          y;
    logic          last;
    logic          par;
  } beat_t;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic [SIZE-1:0] i_x = '0, i_y = '0;
  logic            i_start = 1'b0, i_ready = 1'b1, i_drop_clr = 1'b0;
  logic            o_valid, o_x, o_y, o_last, o_par, o_busy, o_drop;
  logic [LW-1:0]   o_lane;

  int    n_pass = 0;
  int    n_tot  = 0;
  beat_t exp_q[$];

  lane_serializer #(.SIZE(SIZE)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_x(i_x), .i_y(i_y),
    .i_start(i_start), .i_ready(i_ready), .i_drop_clr(i_drop_clr),
    .o_valid(o_valid), .o_lane(o_lane), .o_x(o_x), .o_y(o_y),
    .o_last(o_last), .o_par(o_par), .o_busy(o_busy), .o_drop(o_drop)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Expected frame for x=A5,y=3D written out lane by lane (x,y per lane 0..7).
  task automatic push_frame();
    logic [1:0] xy [SIZE] = '{2'b11, 2'b00, 2'b11, 2'b01, 2'b01, 2'b11, 2'b00, 2'b10};
    beat_t b;
    for (int k = 0; k < SIZE; k++) begin
      b.lane = LW'(k);
      b.x    = xy[k][1];
      b.y    = xy[k][0];
`ifdef LANE_SERIALIZER_PARITY_EN
      b.last = 1'b0;
`else
      b.last = (k == SIZE - 1);
`endif
      b.par  = 1'b0;
      exp_q.push_back(b);
    end
`ifdef LANE_SERIALIZER_PARITY_EN
    b.lane = '0; b.x = 1'b0; b.y = 1'b1; b.last = 1'b1; b.par = 1'b1;
    exp_q.push_back(b);
`endif
  endtask

  // Monitor: each transferring beat is compared against the scoreboard head.
  initial begin
    beat_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {o_lane, o_x, o_y, o_last, o_par}, 32'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {o_lane, o_x, o_y, o_last, o_par}, e);
        end
      end
    end
  end

  task automatic start_frame();
    i_start = 1'b1;
    push_frame();
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge i_clk); t++;
    end
    if (t >= 100) chk({name, "_timeout"}, 0, 1);
    @(posedge i_clk); #1;
    chk({name, "_busy_end"}, {o_valid, o_busy}, 2'b00);
  endtask

  task automatic wait_lane(input logic [LW-1:0] ln);
    int t = 0;
    while (!(o_valid && o_lane == ln && !o_par) && t < 50) begin
      @(posedge i_clk); #1; t++;
    end
    if (t >= 50) chk("wait_lane_timeout", 0, 1);
  endtask

  initial begin
    #12;
    chk("reset_outs", {o_valid, o_lane, o_x, o_y, o_last, o_par, o_busy, o_drop}, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    i_x = 8'hA5; i_y = 8'h3D;

    // basic frame, 1-cycle latency
    start_frame();
    chk("latency_valid", {o_valid, o_busy, o_lane}, {2'b11, 3'd0});
    wait_drain("basic");

    // backpressure on frame cycles 2-4 holding lane 1
    start_frame();
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("hold_lane1", {o_valid, o_lane, o_x, o_y}, {1'b1, 3'd1, 1'b0, 1'b0});
      @(posedge i_clk); #1;
    end
    i_ready = 1'b1;
    wait_drain("bp");

    // snapshot isolation
    start_frame();
    @(posedge i_clk); #1;
    i_x = 8'hFF; i_y = 8'h00;
    wait_drain("snap");
    i_x = 8'hA5; i_y = 8'h3D;

    // drop: start during lane 3, clear, then set+clr on final transfer
    start_frame();
    wait_lane(3'd3);
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    chk("drop_set", o_drop, 1);
    @(posedge i_clk); #1;
    chk("drop_sticky", o_drop, 1);
    i_drop_clr = 1'b1;
    @(posedge i_clk); #1;
    i_drop_clr = 1'b0;
    chk("drop_clr", o_drop, 0);
    begin
      int t = 0;
      while (!o_last && t < 50) begin @(posedge i_clk); #1; t++; end
      if (t >= 50) chk("last_timeout", 0, 1);
    end
    i_start = 1'b1; i_drop_clr = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_drop_clr = 1'b0;
    chk("drop_set_wins", o_drop, 1);
    chk("final_start_ignored", {o_valid, o_busy}, 2'b00);
    @(posedge i_clk); #1;
    chk("no_new_frame", {o_valid, o_busy}, 2'b00);
    chk("queue_empty_drop", exp_q.size(), 0);
    i_drop_clr = 1'b1;
    @(posedge i_clk); #1;
    i_drop_clr = 1'b0;

    // reset mid-frame
    start_frame();
    wait_lane(3'd5);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("async_reset_outs", {o_valid, o_lane, o_x, o_y, o_last, o_par, o_busy, o_drop}, 0);
    exp_q.delete();
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge i_clk); #1;
      chk("post_reset_idle", {o_valid, o_busy}, 2'b00);
    end

    // fresh frame after reset
    start_frame();
    wait_drain("after_reset");
    chk("queue_empty_end", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/lane_serializer.md
Name: lane_serializer

Overview:
- Downstream consumer of an interface-array stage: takes the per-lane `x`/`y` bit vectors that the top level flattens out of an array of `SIZE` interfaces.
- On request, snapshots both vectors and streams them out one lane per beat over a valid/ready handshake.
- Feeds a narrow serial sink (debug/trace port) so a wide interface array can be observed lane by lane.

Parameters:
- SIZE, 8, number of interface lanes; legal range ≥ 2.
- LANE_W, $clog2(SIZE), width of the lane index; derived, never overridden.

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_x  input  SIZE  per-lane `x` bits (bit k = lane k).
- i_y  input  SIZE  per-lane `y` bits (bit k = lane k).
- i_start  input  1  capture request; single-cycle pulse or level.
- i_ready  input  1  sink ready.
- i_drop_clr  input  1  clears o_drop.
- o_valid  output  1  beat valid.
- o_lane  output  LANE_W  lane index of current beat.
- o_x  output  1  snapshot `x` bit of o_lane.
- o_y  output  1  snapshot `y` bit of o_lane.
- o_last  output  1  final beat of the frame.
- o_par  output  1  current beat is the parity beat.
- o_busy  output  1  frame in progress.
- o_drop  output  1  sticky: an i_start was ignored.

Behaviour:
- Reset (async assert, sync deassert edge on i_clk):
  - State = IDLE.
  - o_valid, o_lane, o_x, o_y, o_last, o_par, o_busy, o_drop = 0.
  - Snapshot registers = 0.
- FSM states: IDLE, SEND, and PAR (PAR exists only with the optional feature).
- IDLE:
  - i_start=1 at edge n loads snap_x←i_x, snap_y←i_y and sets lane counter=0.
  - Next state is SEND. o_valid=1 and o_busy=1 from cycle n+1, so latency is 1 cycle.
- SEND:
  - o_lane=counter, o_x=snap_x[counter], o_y=snap_y[counter].
  - o_last=1 when counter==SIZE-1 and the feature is disabled.
- Handshake:
  - A beat transfers on an edge where o_valid && i_ready.
  - While i_ready=0 the beat holds: o_lane, o_x, o_y, o_last, o_par stay stable and o_valid does not drop.
  - On transfer with counter<SIZE-1, counter increments by 1.
  - On transfer of lane SIZE-1, go to IDLE (or PAR with the feature enabled).
- Frame end:
  - After the final transfer, o_valid=0 and o_busy=0 on the next cycle.
  - The counter does not wrap; it resets to 0 only on a new capture.
- Busy start:
  - i_start=1 in any non-IDLE state, including the final-transfer cycle, is ignored.
  - It sets o_drop=1 on the next edge. The snapshot is unchanged.
  - Back-to-back frames therefore need ≥1 IDLE cycle.
- o_drop:
  - Sticky; cleared by i_drop_clr=1.
  - If a set event and i_drop_clr coincide, set wins.
- Inputs i_x/i_y are sampled only at capture; later changes do not affect the frame in flight.
- Reset mid-frame aborts immediately: outputs go to reset values and no partial frame resumes.
- i_ready is ignored while o_valid=0.

Optional Feature:
- Macro: LANE_SERIALIZER_PARITY_EN.
- Defined:
  - After lane SIZE-1 transfers, state=PAR and one extra beat is sent.
  - PAR beat: o_lane=0, o_x=^snap_x, o_y=^snap_y, o_par=1, o_last=1.
  - Lane SIZE-1 then has o_last=0.
  - Transfer of the PAR beat returns to IDLE.
- Undefined:
  - No PAR state exists.
  - o_par is tied 0 and o_last marks lane SIZE-1.
- Port list is identical in both builds.

Decomposition:
- Package lane_serializer_pkg:
  - localparam int SIZE=8 default.
  - Function for LANE_W.
  - typedef enum logic [1:0] {IDLE, SEND, PAR} state_t.
- No sub-module is natural: snapshot, counter and FSM form one block. The module imports the package.

Test Plan:
- Basic frame: SIZE=8, i_x=8'hA5, i_y=8'h3D, i_ready=1, pulse i_start.
  - Expect 8 consecutive beats, lanes 0..7.
  - (x,y) sequence: lane0=(1,1), lane1=(0,0), lane2=(1,1), lane7=(1,0).
  - o_last only on lane 7; o_busy low the cycle after.
- Backpressure: same stimulus, i_ready=0 on cycles 2–4 of the frame.
  - Lane 1 held stable for 3 cycles with o_valid=1.
  - Frame completes with 8 transfers total; no lane skipped or repeated.
- Snapshot isolation: change i_x to 8'hFF mid-frame.
  - Remaining beats still reflect 8'hA5.
- Drop: assert i_start during lane 3 and again on the final-transfer cycle.
  - o_drop=1 and stays 1; frame unaffected.
  - i_drop_clr → o_drop=0; simultaneous set+clr → o_drop=1.
- Reset mid-frame: deassert i_rst_n at lane 5.
  - All outputs 0 immediately (asynchronously).
  - After release, no beats appear until a new i_start.
- Parity (macro defined): i_x=8'hA5, i_y=8'h3D.
  - 9th beat has o_par=1, o_x=0, o_y=1, o_last=1.
  - Lane 7 beat has o_last=0.
